// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with branch-mask squash
//
// Purpose: picks one functional-unit result per cycle in round-robin order,
// registers it, and broadcasts it on the CDB one cycle later. Results whose
// branch mask hits a mispredicting branch are squashed before arbitration
// and again during the broadcast cycle.
//
// Ports:
//   clock         sole clock, posedge
//   reset         asynchronous, active-low
//   fu_valid      per-FU request
//   fu_result     per-FU result packet (result, completing_reg, valid)
//   fu_bm         per-FU branch mask of the offered result
//   b_mm_resolve  one-hot resolving branch bit, zero when none
//   b_mm_mispred  resolving branch mispredicted
//   fu_grant      combinational one-hot (or zero) consume strobe per FU
//   cdb_valid     broadcast valid this cycle
//   cdb_packet    registered broadcast packet
//   cdb_bm        registered branch mask of the broadcast

package cdb_arbiter_pkg;
   localparam int XLEN  = 32;
   localparam int REG_W = 6;
   localparam int BM_W  = 4;

   typedef logic [BM_W-1:0] b_mask_t;

   typedef struct packed {
      logic [XLEN-1:0]  result;
      logic [REG_W-1:0] completing_reg;
      logic             valid;
   } cdb_reg_packet_t;
endpackage

module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_FU-1:0]   fu_valid,
   input  cdb_reg_packet_t     fu_result [NUM_FU],
   input  b_mask_t             fu_bm     [NUM_FU],
   input  b_mask_t             b_mm_resolve,
   input  logic                b_mm_mispred,
   output logic [NUM_FU-1:0]   fu_grant,
   output logic                cdb_valid,
   output cdb_reg_packet_t     cdb_packet,
   output b_mask_t             cdb_bm
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             valid_q, valid_d;
   cdb_reg_packet_t  packet_q, packet_d;
   b_mask_t          bm_q, bm_d;

   logic [NUM_FU-1:0] eligible;
   logic              any_grant;
   logic [PTR_W-1:0]  grant_idx;

   // A result is squashed before arbitration when it depends on the
   // branch that is resolving as mispredicted this cycle.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         eligible[i] = fu_valid[i] & ~(b_mm_mispred & (|(fu_bm[i] & b_mm_resolve)));
      end
   end

   // Scan rr_ptr, rr_ptr+1, ... with wrap; first eligible index wins.
   always_comb begin
      logic [PTR_W:0] sum;
      logic [PTR_W-1:0] idx;
      any_grant = 1'b0;
      grant_idx = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_FU)) begin
            sum = sum - (PTR_W+1)'(NUM_FU);
         end
         idx = sum[PTR_W-1:0];
         if (!any_grant && eligible[idx]) begin
            any_grant = 1'b1;
            grant_idx = idx;
         end
      end
   end

   // Grant is suppressed while reset is held so nothing is consumed
   // by an FU during an asynchronous reset window.
   always_comb begin
      fu_grant = '0;
      if (any_grant && reset) begin
         fu_grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      valid_d  = any_grant;
      packet_d = packet_q;
      bm_d     = bm_q;
      rr_ptr_d = rr_ptr_q;
      if (any_grant) begin
         packet_d = fu_result[grant_idx];
         // The resolving branch is known-correct or this result would have
         // been squashed, so its bit no longer applies to the broadcast.
         bm_d     = fu_bm[grant_idx] & ~b_mm_resolve;
         rr_ptr_d = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q <= '0;
         valid_q  <= 1'b0;
         packet_q <= '0;
         bm_q     <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         valid_q  <= valid_d;
         packet_q <= packet_d;
         bm_q     <= bm_d;
      end
   end

   // A registered broadcast can still be killed by a branch resolving in
   // its broadcast cycle; the stored mask itself is left untouched.
   assign cdb_valid  = valid_q & ~(b_mm_mispred & (|(bm_q & b_mm_resolve)));
   assign cdb_packet = packet_q;
   assign cdb_bm     = bm_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 4;

   logic            clock;
   logic            reset;
   logic [N-1:0]    fu_valid;
   cdb_reg_packet_t fu_result [N];
   b_mask_t         fu_bm     [N];
   b_mask_t         b_mm_resolve;
   logic            b_mm_mispred;
   logic [N-1:0]    fu_grant;
   logic            cdb_valid;
   cdb_reg_packet_t cdb_packet;
   b_mask_t         cdb_bm;

   int n_vec = 0;
   int n_err = 0;

   cdb_arbiter #(.NUM_FU(N)) dut (
      .clock        (clock),
      .reset        (reset),
      .fu_valid     (fu_valid),
      .fu_result    (fu_result),
      .fu_bm        (fu_bm),
      .b_mm_resolve (b_mm_resolve),
      .b_mm_mispred (b_mm_mispred),
      .fu_grant     (fu_grant),
      .cdb_valid    (cdb_valid),
      .cdb_packet   (cdb_packet),
      .cdb_bm       (cdb_bm)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pointer as an integer, the pending broadcast as a
   // plain record. Evaluated at negedge, when inputs are stable until the
   // next posedge consumes them.
   int              m_rr  = 0;
   bit              m_vld = 0;
   cdb_reg_packet_t m_pkt;
   b_mask_t         m_bm;

   always @(negedge clock) begin
      bit         elig [N];
      int         g;
      logic [N-1:0] exp_grant;
      bit         exp_cv;
      if (!reset) begin
         chk("model_grant_rst", 64'(fu_grant), 64'(0));
         chk("model_cdbv_rst", 64'(cdb_valid), 64'(0));
         m_rr  = 0;
         m_vld = 0;
      end else begin
         for (int i = 0; i < N; i++)
            elig[i] = fu_valid[i] && !(b_mm_mispred && ((fu_bm[i] & b_mm_resolve) != 0));
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && elig[(m_rr + k) % N]) g = (m_rr + k) % N;
         end
         exp_grant = (g < 0) ? '0 : (N'(1) << g);
         exp_cv = m_vld && !(b_mm_mispred && ((m_bm & b_mm_resolve) != 0));
         chk("model_grant", 64'(fu_grant), 64'(exp_grant));
         chk("model_cdb_valid", 64'(cdb_valid), 64'(exp_cv));
         if (m_vld) begin
            chk("model_cdb_reg", 64'(cdb_packet.completing_reg), 64'(m_pkt.completing_reg));
            chk("model_cdb_result", 64'(cdb_packet.result), 64'(m_pkt.result));
            chk("model_cdb_bm", 64'(cdb_bm), 64'(m_bm));
         end
         if (g >= 0) begin
            m_rr  = (g + 1) % N;
            m_vld = 1;
            m_pkt = fu_result[g];
            m_bm  = fu_bm[g] & ~b_mm_resolve;
         end else begin
            m_vld = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
      #1;
   endtask

   initial begin
      reset        = 1'b0;
      fu_valid     = '1;
      b_mm_resolve = '0;
      b_mm_mispred = 1'b0;
      for (int i = 0; i < N; i++) begin
         fu_result[i].result         = 32'(100 + i);
         fu_result[i].completing_reg = 6'(10 + i);
         fu_result[i].valid          = 1'b1;
         fu_bm[i]                    = '0;
      end
      #2;
      chk("reset_grant", 64'(fu_grant), 64'(0));
      chk("reset_cdb_valid", 64'(cdb_valid), 64'(0));
      cyc();
      cyc();
      reset = 1'b1;

      // All four valid from reset: 0001,0010,0100,1000,0001
      for (int n = 0; n < 5; n++) begin
         mid();
         chk("rr_grant", 64'(fu_grant), 64'(N'(1) << (n % N)));
         if (n > 0) begin
            chk("rr_cdb_valid", 64'(cdb_valid), 64'(1));
            chk("rr_cdb_reg", 64'(cdb_packet.completing_reg), 64'(10 + ((n - 1) % N)));
         end
         cyc();
      end
      fu_valid = '0;
      mid();
      chk("rr_last_reg", 64'(cdb_packet.completing_reg), 64'(10));

      // Reset pulse, then FU2 alone with completing_reg 7
      cyc();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      fu_valid = 4'b0100;
      fu_result[2].completing_reg = 6'd7;
      mid();
      chk("fu2_grant", 64'(fu_grant), 64'(4'b0100));
      cyc();
      fu_valid = '0;
      mid();
      chk("fu2_cdb_valid", 64'(cdb_valid), 64'(1));
      chk("fu2_cdb_reg", 64'(cdb_packet.completing_reg), 64'(7));
      chk("fu2_no_regrant", 64'(fu_grant), 64'(0));
      cyc();
      fu_valid = '1;
      mid();
      chk("rr_ptr_3", 64'(fu_grant), 64'(4'b1000));
      cyc();

      // Bring rr_ptr to 1, then squash FU1 while FU3 requests
      fu_valid = 4'b0001;
      mid();
      chk("pre_squash_grant", 64'(fu_grant), 64'(4'b0001));
      cyc();
      fu_valid     = 4'b1010;
      fu_bm[1]     = 4'b0010;
      b_mm_resolve = 4'b0010;
      b_mm_mispred = 1'b1;
      mid();
      chk("squash_grant", 64'(fu_grant), 64'(4'b1000));
      cyc();
      fu_valid     = '0;
      fu_bm[1]     = '0;
      b_mm_resolve = '0;
      b_mm_mispred = 1'b0;

      // Broadcast killed in its own cycle; stored mask unchanged
      fu_valid = 4'b0001;
      fu_bm[0] = 4'b0100;
      mid();
      chk("kill_grant", 64'(fu_grant), 64'(4'b0001));
      cyc();
      fu_valid     = '0;
      fu_bm[0]     = '0;
      b_mm_resolve = 4'b0100;
      b_mm_mispred = 1'b1;
      mid();
      chk("kill_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("kill_cdb_bm", 64'(cdb_bm), 64'(4'b0100));
      cyc();
      b_mm_resolve = '0;
      b_mm_mispred = 1'b0;

      // Correctly predicted branch bit cleared at capture
      fu_valid     = 4'b0001;
      fu_bm[0]     = 4'b0110;
      b_mm_resolve = 4'b0010;
      mid();
      chk("clear_grant", 64'(fu_grant), 64'(4'b0001));
      cyc();
      fu_valid     = '0;
      fu_bm[0]     = '0;
      b_mm_resolve = '0;
      mid();
      chk("clear_cdb_valid", 64'(cdb_valid), 64'(1));
      chk("clear_cdb_bm", 64'(cdb_bm), 64'(4'b0100));
      cyc();

      // Asynchronous reset mid-broadcast
      fu_valid = 4'b0010;
      mid();
      chk("pre_rst_grant", 64'(fu_grant), 64'(4'b0010));
      cyc();
      fu_valid = '1;
      chk("pre_rst_cdb_valid", 64'(cdb_valid), 64'(1));
      reset = 1'b0;
      #1;
      chk("async_rst_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("async_rst_grant", 64'(fu_grant), 64'(0));
      cyc();
      reset    = 1'b1;
      fu_valid = 4'b1000;
      mid();
      chk("post_rst_grant", 64'(fu_grant), 64'(4'b1000));
      cyc();
      fu_valid = '1;
      mid();
      chk("post_rst_cdb_reg", 64'(cdb_packet.completing_reg), 64'(13));
      chk("post_rst_rr0", 64'(fu_grant), 64'(4'b0001));
      cyc();

      // Mixed traffic checked by the model alone
      for (int c = 0; c < 300; c++) begin
         int r;
         fu_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            fu_result[i].result         = $urandom;
            fu_result[i].completing_reg = 6'($urandom);
            fu_bm[i]                    = b_mask_t'($urandom);
         end
         r = int'($urandom_range(0, 2));
         b_mm_resolve = (r == 0) ? (b_mask_t'(1) << $urandom_range(0, BM_W - 1)) : '0;
         b_mm_mispred = (b_mm_resolve != 0) ? 1'($urandom) : 1'b0;
         cyc();
      end
      fu_valid     = '0;
      b_mm_resolve = '0;
      b_mm_mispred = 1'b0;
      cyc();
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4: number of functional-unit requesters, range 2..8.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1  reset is asynchronous and active-low.
REQ-004 SHALL have port fu_valid  in  NUM_FU  per-FU request; FU holds its result stable while fu_valid=1 and fu_grant=0.
REQ-005 SHALL have port fu_result  in  CDB_REG_PACKET[NUM_FU]  per-FU result (result, completing_reg, valid).
REQ-006 SHALL have port fu_bm  in  B_MASK[NUM_FU]  per-FU branch mask of the offered result.
REQ-007 SHALL have port b_mm_resolve  in  B_MASK  one-hot resolving branch bit, 0 when none.
REQ-008 SHALL have port b_mm_mispred  in  1  resolving branch mispredicted.
REQ-009 SHALL have port fu_grant  out  NUM_FU  per-FU cdb_en; combinational, one-hot or zero.
REQ-010 SHALL have port cdb_valid  out  1  broadcast valid this cycle.
REQ-011 SHALL have port cdb_packet  out  CDB_REG_PACKET  registered broadcast (result, completing_reg).
REQ-012 SHALL have port cdb_bm  out  B_MASK  registered branch mask of the broadcast.

Function
REQ-013 SHALL treat FU i as eligible when fu_valid[i]=1 and not (b_mm_mispred=1 and |(fu_bm[i] & b_mm_resolve)).
REQ-014 SHALL grant at most one eligible FU per cycle; fu_grant[i]=1 only if FU i eligible.
REQ-015 SHALL select round-robin: first eligible index scanning rr_ptr, rr_ptr+1, ... mod NUM_FU.
REQ-016 SHALL update rr_ptr <= (granted index + 1) mod NUM_FU on a grant; hold rr_ptr when no grant.
REQ-017 SHALL assert a grant whenever at least one FU is eligible (work-conserving; no idle cycles).
REQ-018 Handshake: fu_grant[i]=1 at edge t means FU i's result is consumed at edge t; the FU advances at the same edge.
REQ-019 SHALL register on a grant: cdb_packet <= fu_result[i] (fields copied unchanged), cdb_bm <= fu_bm[i] & ~b_mm_resolve, internal valid <= 1.
REQ-020 SHALL register internal valid <= 0 when no grant; cdb_packet/cdb_bm don't-care then.
REQ-021 Latency: grant in cycle t -> broadcast visible in cycle t+1, exactly one cycle.
REQ-022 SHALL drive cdb_valid = internal valid & ~(b_mm_mispred & |(cdb_bm & b_mm_resolve)) combinationally (kill of a registered broadcast squashed in its broadcast cycle).
REQ-023 SHALL not modify the registered cdb_bm in the broadcast cycle; the clear in REQ-019 applies only at capture.
REQ-024 Mispredict and grant in same cycle: squashed FUs are excluded before arbitration; grant goes to next eligible FU in round-robin order.
REQ-025 rr_ptr wrap: after granting index NUM_FU-1, rr_ptr SHALL be 0.
REQ-026 SHALL never broadcast a result twice nor drop a granted, unsquashed result.

Reset
REQ-027 While reset=0 (asynchronously): internal valid=0, rr_ptr=0; cdb_valid=0 and fu_grant=0 immediately.
REQ-028 First edge after reset deasserts SHALL arbitrate normally from rr_ptr=0.
REQ-029 Reset asserted mid-broadcast SHALL drop the in-flight result; cdb_valid=0 without waiting for a clock.

Verification
REQ-030 All 4 FUs valid continuously from reset -> fu_grant 0001,0010,0100,1000,0001; cdb_packet.completing_reg tracks each one cycle later.
REQ-031 Only FU2 valid, rr_ptr=0, completing_reg=7 -> fu_grant=0100 same cycle; next cycle cdb_valid=1, completing_reg=7; rr_ptr=3.
REQ-032 FU1 fu_bm=0010, FU3 valid, rr_ptr=1, resolve=0010, mispred=1 -> fu_grant=1000; FU1 not granted.
REQ-033 Registered broadcast cdb_bm=0100; next cycle resolve=0100, mispred=1 -> cdb_valid=0 that cycle.
REQ-034 Grant to FU0 with fu_bm=0110, resolve=0010, mispred=0 -> next cycle cdb_valid=1, cdb_bm=0100.
REQ-035 reset driven low between edges while cdb_valid=1 -> cdb_valid=0 and fu_grant=0 before next edge; after release, FU3-only request -> grant 1000, rr_ptr=0.
